// File: rtl/correlation_pkg.sv
// Shared types and width helpers for the streaming LUT correlator.
package correlation_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    FILL
  } fillState_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int defaultCoef(input int tap);
    return tap + 1;
  endfunction

  function automatic int productWidth(input int xWidth, input int hWidth);
    return xWidth + hWidth;
  endfunction

  function automatic int sumWidth(input int pWidth, input int nTaps);
    return pWidth + clog2(nTaps);
  endfunction

  function automatic int lutDepth(input int xWidth);
    return 1 << xWidth;
  endfunction

endpackage

// File: rtl/product_lut.sv
// One tap's product table: a synchronous write port driven by the fill
// engine and a registered read port that forms the first pipeline stage.
module product_lut
  import correlation_pkg::*;
#(
  parameter int X_WIDTH = 4,
  parameter int P_WIDTH = 8
) (
  input  logic               clock,
  input  logic               i_wrEn,
  input  logic [X_WIDTH-1:0] i_wrAddr,
  input  logic [P_WIDTH-1:0] i_wrData,
  input  logic [X_WIDTH-1:0] i_rdAddr,
  output logic [P_WIDTH-1:0] o_rdData
);

  localparam int DEPTH = lutDepth(X_WIDTH);

  logic [P_WIDTH-1:0] r_mem [DEPTH];
  logic [P_WIDTH-1:0] r_rdData;

  // Table write from the fill engine and registered product lookup
  always_ff @(posedge clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/correlation_stream.sv
// Streaming correlator: sample window feeding per-tap product LUTs, a
// two-stage pipeline to the registered sum, and a fill engine that builds
// each LUT by repeated addition of the tap coefficient.
module correlation_stream
  import correlation_pkg::*;
#(
  parameter int N_TAPS  = 10,
  parameter int X_WIDTH = 4,
  parameter int H_WIDTH = 4,
  parameter int P_WIDTH = productWidth(X_WIDTH, H_WIDTH),
  parameter int Y_WIDTH = sumWidth(P_WIDTH, N_TAPS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [X_WIDTH-1:0]       x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     coef_we,
  input  logic [clog2(N_TAPS)-1:0] coef_addr,
  input  logic [H_WIDTH-1:0]       coef_data,
  output logic                     coef_ready,
  output logic                     busy,
  output logic [Y_WIDTH-1:0]       y,
  output logic                     y_valid
);

  localparam int A_WIDTH = clog2(N_TAPS);
  localparam int C_WIDTH = clog2(N_TAPS + 1);

  fillState_e         r_state;
  fillState_e         w_stateNext;
  logic [A_WIDTH-1:0] r_fillTap;
  logic [X_WIDTH-1:0] r_fillIdx;
  logic [P_WIDTH-1:0] r_acc;
  logic [H_WIDTH-1:0] r_fillCoef;
  logic [H_WIDTH-1:0] w_fillCoef;
  logic               w_idxLast;
  logic               w_lastTap;
  logic               w_lutWe;
  logic               w_busy;
  logic [N_TAPS-1:0]  w_tapWe;

  logic [X_WIDTH-1:0] r_win     [N_TAPS-1];
  logic [X_WIDTH-1:0] w_nextWin [N_TAPS];
  logic [P_WIDTH-1:0] w_prod    [N_TAPS];
  logic               w_accept;
  logic [C_WIDTH-1:0] r_count;
  logic               r_s1Valid;
  logic [Y_WIDTH-1:0] w_sum;
  logic [Y_WIDTH-1:0] r_y;
  logic               r_yValid;

  assign w_idxLast  = (r_fillIdx == '1);
  assign w_lastTap  = (r_fillTap == A_WIDTH'(N_TAPS - 1));
  assign w_fillCoef = (r_state == INIT) ? H_WIDTH'(defaultCoef(int'(r_fillTap))) : r_fillCoef;

  assign busy       = w_busy;
  assign coef_ready = !w_busy;
  assign x_ready    = !w_busy && !coef_we;
  assign w_accept   = x_valid && x_ready;

  // Fill FSM state register; reset always restarts the default-table build
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fill FSM next state, busy flag and LUT write strobe
  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b1;
    w_lutWe     = 1'b0;
    case (r_state)
      INIT: begin
        w_lutWe = 1'b1;
        if (w_idxLast && w_lastTap) begin
          w_stateNext = IDLE;
        end
      end
      IDLE: begin
        w_busy = 1'b0;
        if (coef_we) begin
          w_stateNext = FILL;
        end
      end
      FILL: begin
        w_lutWe = 1'b1;
        if (w_idxLast) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = INIT;
      end
    endcase
  end

  // Fill engine: walks entries, accumulating h per entry; r_fillTap counts taps in INIT and holds the target tap in FILL
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fillTap  <= '0;
      r_fillIdx  <= '0;
      r_acc      <= '0;
      r_fillCoef <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_fillIdx <= r_fillIdx + X_WIDTH'(1);
          if (w_idxLast) begin
            r_acc     <= '0;
            r_fillTap <= r_fillTap + A_WIDTH'(1);
          end else begin
            r_acc <= r_acc + P_WIDTH'(w_fillCoef);
          end
        end
        IDLE: begin
          if (coef_we) begin
            r_fillTap  <= coef_addr;
            r_fillCoef <= coef_data;
            r_fillIdx  <= '0;
            r_acc      <= '0;
          end
        end
        FILL: begin
          r_fillIdx <= r_fillIdx + X_WIDTH'(1);
          if (w_idxLast) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + P_WIDTH'(w_fillCoef);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shifted window as seen by the LUT read ports; tap 0 is the incoming sample
  always_comb begin
    w_nextWin[0] = x_in;
    for (int k = 1; k < N_TAPS; k++) begin
      w_nextWin[k] = r_win[k-1];
    end
  end

  // Only the N_TAPS-1 newest samples need storing; the oldest falls off on the next shift
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS - 1; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < N_TAPS - 1; k++) begin
        r_win[k] <= w_nextWin[k];
      end
    end
  end

  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    assign w_tapWe[k] = w_lutWe && (r_fillTap == A_WIDTH'(k));

    product_lut #(
      .X_WIDTH(X_WIDTH),
      .P_WIDTH(P_WIDTH)
    ) u_lut (
      .clock   (clock),
      .i_wrEn  (w_tapWe[k]),
      .i_wrAddr(r_fillIdx),
      .i_wrData(r_acc),
      .i_rdAddr(w_nextWin[k]),
      .o_rdData(w_prod[k])
    );
  end

  // Warm-up counter and stage-1 valid; results are suppressed until the window is full
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      if (w_accept && (r_count != C_WIDTH'(N_TAPS))) begin
        r_count <= r_count + C_WIDTH'(1);
      end
      r_s1Valid <= w_accept && (r_count >= C_WIDTH'(N_TAPS - 1));
    end
  end

  // Sum of all tap products, widened so no partial sum can overflow
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_sum = w_sum + Y_WIDTH'(w_prod[k]);
    end
  end

  // Stage 2: register the sum; y holds between valid pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_y      <= '0;
      r_yValid <= 1'b0;
    end else begin
      r_yValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_y <= w_sum;
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_yValid;

endmodule

// File: tb/tb_correlation_stream.sv
// Randomised scoreboard bench for correlation_stream: stimulus updates a
// window/coefficient model and queues expected sums; a monitor pops them
// whenever the DUT presents y_valid.
module tb_correlation_stream;

  localparam int N_TAPS    = 10;
  localparam int X_WIDTH   = 4;
  localparam int H_WIDTH   = 4;
  localparam int A_WIDTH   = 4;
  localparam int Y_WIDTH   = 12;
  localparam int LUT_DEPTH = 16;

  logic               clock;
  logic               reset;
  logic [X_WIDTH-1:0] x_in;
  logic               x_valid;
  logic               x_ready;
  logic               coef_we;
  logic [A_WIDTH-1:0] coef_addr;
  logic [H_WIDTH-1:0] coef_data;
  logic               coef_ready;
  logic               busy;
  logic [Y_WIDTH-1:0] y;
  logic               y_valid;

  int errors;
  int checks;

  int h [N_TAPS];
  int hist [$];
  int sbQueue [$];
  int warm;
  int fillLeft;
  int monExp;
  longint lastY;

  correlation_stream #(
    .N_TAPS (N_TAPS),
    .X_WIDTH(X_WIDTH),
    .H_WIDTH(H_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_ready(coef_ready),
    .busy      (busy),
    .y         (y),
    .y_valid   (y_valid)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop if the run never reaches its summary
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelDefaults();
    for (int k = 0; k < N_TAPS; k++) begin
      h[k] = (k + 1) % (1 << H_WIDTH);
    end
  endtask

  // Reference model: y is the dot product of coefficients with the newest N_TAPS samples
  task automatic modelAccept(input int x);
    int s;
    hist.push_front(x);
    if (hist.size() > N_TAPS) begin
      void'(hist.pop_back());
    end
    warm++;
    if (warm >= N_TAPS) begin
      s = 0;
      for (int k = 0; k < N_TAPS; k++) begin
        s += h[k] * hist[k];
      end
      sbQueue.push_back(s);
    end
  endtask

  // Drive one cycle of inputs, check handshake outputs against the model, then advance the model
  task automatic applyStimulus(input logic [X_WIDTH-1:0] x, input logic v, input logic we,
                               input logic [A_WIDTH-1:0] a, input logic [H_WIDTH-1:0] d);
    logic expC;
    logic expX;
    x_in      = x;
    x_valid   = v;
    coef_we   = we;
    coef_addr = a;
    coef_data = d;
    expC = (fillLeft == 0);
    expX = expC && !we;
    @(negedge clock);
    checkOutput("x_ready", longint'(x_ready), longint'(expX));
    checkOutput("coef_ready", longint'(coef_ready), longint'(expC));
    checkOutput("busy", longint'(busy), longint'(!expC));
    @(posedge clock);
    #1;
    if (fillLeft > 0) begin
      fillLeft--;
    end
    if (we && expC) begin
      fillLeft = LUT_DEPTH;
      if (int'(a) < N_TAPS) begin
        h[a] = int'(d);
      end
    end
    if (v && expX) begin
      modelAccept(int'(x));
    end
    x_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus('0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic writeCoef(input int a, input int d);
    applyStimulus('0, 1'b0, 1'b1, A_WIDTH'(a), H_WIDTH'(d));
    while (fillLeft > 0) begin
      applyStimulus('0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Count the busy cycles of the default-table build; offers a sample throughout
  task automatic countInitBusy();
    int n;
    int bad;
    n   = 0;
    bad = 0;
    x_in    = 4'd5;
    x_valid = 1'b1;
    coef_we = 1'b0;
    while (n < 1000) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (x_ready || y_valid || coef_ready) bad++;
    end
    x_valid = 1'b0;
    checkOutput("init_busy_cycles", longint'(n), longint'(N_TAPS * LUT_DEPTH));
    checkOutput("init_ready_or_valid_cycles", longint'(bad), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    x_valid = 1'b0;
    coef_we = 1'b0;
    sbQueue.delete();
    @(posedge clock);
    #1;
    checkOutput("reset_y", longint'(y), 0);
    checkOutput("reset_y_valid", longint'(y_valid), 0);
    checkOutput("reset_busy", longint'(busy), 1);
    checkOutput("reset_x_ready", longint'(x_ready), 0);
    checkOutput("reset_coef_ready", longint'(coef_ready), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    hist.delete();
    warm     = 0;
    fillLeft = 0;
    modelDefaults();
    countInitBusy();
  endtask

  // Monitor: pop and compare on every y_valid, and confirm y holds otherwise
  always @(negedge clock) begin
    if (reset) begin
      lastY = 0;
    end else if (y_valid) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_y_valid: y_valid=1 y=%0d, expected y_valid=0 at %0t", y, $time);
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("y", longint'(y), longint'(monExp));
      end
      lastY = longint'(y);
    end else begin
      checkOutput("y_hold", longint'(y), lastY);
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    warm      = 0;
    fillLeft  = 0;
    lastY     = 0;
    reset     = 1'b1;
    x_in      = '0;
    x_valid   = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    modelDefaults();

    doReset();

    $display("[TB] ramp 1..10 with default coefficients");
    for (int i = 1; i <= N_TAPS; i++) begin
      applyStimulus(X_WIDTH'(i), 1'b1, 1'b0, '0, '0);
    end
    idle(4);

    $display("[TB] constant full-scale samples");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'd15, 1'b1, 1'b0, '0, '0);
    end
    idle(3);

    $display("[TB] all coefficients at maximum");
    for (int k = 0; k < N_TAPS; k++) begin
      writeCoef(k, 15);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'd15, 1'b1, 1'b0, '0, '0);
    end
    idle(3);

    $display("[TB] restore defaults, then zero tap 3 mid-stream");
    for (int k = 0; k < N_TAPS; k++) begin
      writeCoef(k, k + 1);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'd15, 1'b1, 1'b0, '0, '0);
    end
    applyStimulus(4'd15, 1'b1, 1'b1, 4'd3, 4'd0);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(4'd15, 1'b1, 1'b0, '0, '0);
    end
    idle(3);

    $display("[TB] write/sample collision and out-of-range address");
    applyStimulus(4'd3, 1'b1, 1'b1, 4'd5, 4'd2);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(X_WIDTH'(i), 1'b1, 1'b0, '0, '0);
    end
    applyStimulus(4'd9, 1'b1, 1'b1, 4'd12, 4'd7);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(X_WIDTH'(15 - (i % 16)), 1'b1, 1'b0, '0, '0);
    end
    idle(3);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(X_WIDTH'($urandom_range(0, 15)), ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 15) == 0), A_WIDTH'($urandom_range(0, 15)),
                    H_WIDTH'($urandom_range(0, 15)));
    end
    idle(3);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(X_WIDTH'($urandom_range(0, 15)), 1'b1, 1'b0, '0, '0);
    end
    doReset();

    $display("[TB] reset mid-fill");
    applyStimulus('0, 1'b0, 1'b1, 4'd1, 4'd9);
    idle(8);
    doReset();

    $display("[TB] warm-up restart after reset");
    for (int i = 0; i < N_TAPS + 4; i++) begin
      applyStimulus(X_WIDTH'($urandom_range(0, 15)), 1'b1, 1'b0, '0, '0);
    end
    idle(4);

    checkOutput("scoreboard_pending", longint'(sbQueue.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/correlation_stream.md
# correlation_stream

Streaming, parametrised LUT-based correlator and the successor to the fixed 10-tap correlator. It accepts one sample per cycle through a valid/ready handshake and keeps an N_TAPS-deep sample window. Each tap multiplies through its own product look-up table, and the block emits one registered correlation sum per accepted sample. Coefficients are run-time writable; a sequential fill engine rebuilds a tap's LUT by repeated addition, so the block needs no multipliers.

## Interface
Parameters:
- N_TAPS, 10, number of taps (≥2)
- X_WIDTH, 4, unsigned sample width; each LUT holds 2^X_WIDTH entries
- H_WIDTH, 4, unsigned coefficient width
- P_WIDTH, X_WIDTH+H_WIDTH, product width (derived; do not override)
- Y_WIDTH, P_WIDTH+clog2(N_TAPS), output width (derived; do not override)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- x_in  in  X_WIDTH  input sample
- x_valid  in  1  sample offered
- x_ready  out  1  sample accepted when x_valid && x_ready
- coef_we  in  1  coefficient write request
- coef_addr  in  clog2(N_TAPS)  tap index
- coef_data  in  H_WIDTH  new coefficient
- coef_ready  out  1  a write is accepted when coef_we && coef_ready
- busy  out  1  LUT fill in progress
- y  out  Y_WIDTH  correlation result
- y_valid  out  1  y is valid this cycle (one-cycle pulse per result)

## Operation
- Window: each accepted sample shifts in at tap 0, and older samples move toward tap N_TAPS-1. y = Σ h[k]·x[n-k] for k = 0..N_TAPS-1. All arithmetic is unsigned; no truncation occurs, because Y_WIDTH holds the worst case.
- Product LUT per tap: lut[k][i] = h[k]·i, P_WIDTH bits.
- Fill FSM states and transitions:
  - INIT: entered on reset. Fills every tap with the default coefficient h[k] = k+1 (truncated to H_WIDTH), tap 0 first. Takes N_TAPS·2^X_WIDTH cycles, then moves to IDLE.
  - IDLE: an accepted coef write latches coef_addr/coef_data and moves to FILL.
  - FILL: writes one entry per cycle. The accumulator starts at 0, lut[k][i] ← acc, then acc += h. Takes 2^X_WIDTH cycles, then returns to IDLE.
- busy = 1 in INIT and FILL. coef_ready = !busy. x_ready = !busy && !coef_we.
  - If coef_we and x_valid arrive together in IDLE, the write wins and the sample is not accepted.
- coef_addr ≥ N_TAPS: the write is accepted, a FILL of 2^X_WIDTH cycles runs, and no LUT changes.
- Warm-up: y_valid is suppressed until N_TAPS samples have been accepted since reset. The window and warm-up count are not cleared by a coefficient write.
- Reset mid-operation (any state): clears the window, warm-up count and pipeline, and restarts INIT from tap 0.
- Reset values: x_ready=0, coef_ready=0, busy=1, y=0, y_valid=0.

## Timing
- Sample accepted in cycle t:
  - Stage 1 registers all N_TAPS LUT reads of the shifted window at edge t+1.
  - Stage 2 registers the adder-tree sum into y, with y_valid=1, at edge t+2.
  - Latency is 2 cycles; throughput is 1 sample/cycle.
- Back-to-back samples produce back-to-back y_valid pulses. y holds its value when y_valid=0.
- In-flight results (at most 2) drain normally after busy rises. They use LUT contents read at stage 1.
- A coefficient write accepted at cycle t:
  - busy rises at t+1 and falls after t+2^X_WIDTH.
  - The first sample using the new coefficient can be accepted in the cycle busy is 0.
- After reset deasserts, busy stays high for exactly N_TAPS·2^X_WIDTH cycles.

## Structure
- Package correlation_pkg holds:
  - clog2 function
  - default-coefficient function (k+1)
  - fill FSM state enum {INIT, IDLE, FILL}
  - derived-width localparam helpers
- Sub-module product_lut, one instance per tap (generate loop):
  - 2^X_WIDTH × P_WIDTH register array
  - one synchronous write port (fill engine)
  - one read port registered into stage 1
- The top level holds the shift window, fill FSM and accumulator, warm-up counter, and stage-2 adder tree.

## Test plan
- Reset, then count cycles → busy=1 for exactly 160 cycles (defaults); x_ready=0 and y_valid=0 throughout.
- After init, stream x = 1,2,…,10 on consecutive cycles → a single y_valid two cycles after the 10th sample with y = 220; no earlier y_valid.
- Continuous x=15 → y = 825 every cycle once warm; write h[9..0]=15 then stream x=15 → y = 2250 (no overflow in 12 bits).
- With all x=15 and defaults, write tap 3 ← 0 → coef_ready=0 and busy=1 for 16 cycles, x_ready=0 meanwhile; the next result is y = 765.
- Assert coef_we and x_valid in the same IDLE cycle → write accepted, sample not accepted (x_ready=0), window unchanged.
- Assert reset midway through a FILL and mid-stream → y=0 and y_valid=0 next cycle; a full 160-cycle INIT reruns; warm-up restarts (10 new samples before y_valid).
